// File: rtl/traffic_monitor.sv
// Passive protocol checker for a UK red/amber/green lamp interface.
// Define TRAFFIC_MON_STUCK_EN to build the hold counter and STUCK detection.
module traffic_monitor #(
  parameter int CNT_W    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             clr,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic {UNSYNC = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RA = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_A  = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_BADSEQ  = 2'd2;
  localparam logic [1:0] CODE_STUCK   = 2'd3;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("traffic_monitor: MAX_HOLD must be at least 1");
  end

  state_t           state, state_nx;
  logic [1:0]       phase_nx;
  logic [CNT_W-1:0] cycles_nx;
  logic             legal;
  logic [1:0]       dec;
  logic [1:0]       succ;
  logic             illegal_hit;
  logic             seq_hit;
  logic             stuck_hit;
  logic             new_err;
  logic [1:0]       cause;

  always_comb begin
    legal = 1'b1;
    dec   = PH_R;
    unique case ({red, amber, green})
      3'b100:  dec = PH_R;
      3'b110:  dec = PH_RA;
      3'b001:  dec = PH_G;
      3'b010:  dec = PH_A;
      default: legal = 1'b0;
    endcase
  end

  // The legal sequence R->RA->G->A->R is exactly phase+1 modulo 4.
  assign succ = phase + 2'd1;

  always_comb begin
    state_nx    = state;
    phase_nx    = phase;
    cycles_nx   = cycles;
    illegal_hit = 1'b0;
    seq_hit     = 1'b0;
    unique case (state)
      UNSYNC: begin
        if (legal) begin
          state_nx = LOCKED;
          phase_nx = dec;
        end
      end
      LOCKED: begin
        if (!legal) begin
          illegal_hit = 1'b1;
          state_nx    = UNSYNC;
        end else if (dec != phase) begin
          phase_nx = dec;
          if (dec != succ) begin
            seq_hit = 1'b1;
          end else if ((phase == PH_A) && (cycles != {CNT_W{1'b1}})) begin
            cycles_nx = cycles + CNT_W'(1);
          end
        end
      end
      default: state_nx = UNSYNC;
    endcase
  end

`ifdef TRAFFIC_MON_STUCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hold_cnt, hold_nx;
  logic          hold_sample;

  // Counter saturates at MAX_HOLD so STUCK fires once per hold.
  always_comb begin
    hold_sample = (state == LOCKED) && legal && (dec == phase);
    hold_nx     = '0;
    stuck_hit   = 1'b0;
    if (hold_sample) begin
      hold_nx   = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
      stuck_hit = (hold_cnt == HOLD_MAX - HW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_nx;
  end
`else
  assign stuck_hit = 1'b0;
`endif

  assign new_err = illegal_hit | seq_hit | stuck_hit;

  always_comb begin
    cause = CODE_NONE;
    if (illegal_hit)    cause = CODE_ILLEGAL;
    else if (seq_hit)   cause = CODE_BADSEQ;
    else if (stuck_hit) cause = CODE_STUCK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNSYNC;
      phase    <= PH_R;
      cycles   <= '0;
      err      <= 1'b0;
      err_code <= CODE_NONE;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      cycles <= cycles_nx;
      // A new error overrides a simultaneous clr; otherwise the first cause is held.
      if (new_err && (!err || clr)) begin
        err      <= 1'b1;
        err_code <= cause;
      end else if (clr) begin
        err      <= 1'b0;
        err_code <= CODE_NONE;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor (CNT_W=2, MAX_HOLD=3); the STUCK
// section follows whether TRAFFIC_MON_STUCK_EN is defined.
module tb_traffic_monitor;

  logic       clk = 1'b0;
  logic       rst, red, amber, green, clr;
  logic       locked, err;
  logic [1:0] phase, err_code;
  logic [1:0] cycles;

  int nchecks = 0;
  int nerr    = 0;

  localparam logic [2:0] P_R  = 3'b100;
  localparam logic [2:0] P_RA = 3'b110;
  localparam logic [2:0] P_G  = 3'b001;
  localparam logic [2:0] P_A  = 3'b010;

  traffic_monitor #(.CNT_W(2), .MAX_HOLD(3)) dut (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green), .clr(clr),
    .locked(locked), .phase(phase), .err(err), .err_code(err_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] pat, input logic c);
    {red, amber, green} = pat;
    clr = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic lk, input logic [1:0] ph,
                           input logic e, input logic [1:0] ec);
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    if (lk) chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".err_code"}, 32'(err_code), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; {red, amber, green} = P_G;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 2'd0, 1'b0, 2'd0);
    chk("reset.phase", 32'(phase), 32'd0);
    chk("reset.cycles", 32'(cycles), 32'd0);
    rst = 1'b0;

    // Clean sequence from reset
    drive(P_R, 1'b0);  chk_state("seq.R", 1'b1, 2'd0, 1'b0, 2'd0);
    drive(P_RA, 1'b0); chk_state("seq.RA", 1'b1, 2'd1, 1'b0, 2'd0);
    drive(P_G, 1'b0);  chk_state("seq.G", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(P_A, 1'b0);  chk_state("seq.A", 1'b1, 2'd3, 1'b0, 2'd0);
    chk("seq.cycles0", 32'(cycles), 32'd0);
    drive(P_R, 1'b0);  chk_state("seq.R2", 1'b1, 2'd0, 1'b0, 2'd0);
    drive(P_RA, 1'b0); chk_state("seq.RA2", 1'b1, 2'd1, 1'b0, 2'd0);
    chk("seq.cycles1", 32'(cycles), 32'd1);

    // Bad sequence R->G, then frozen code
    drive(P_G, 1'b0); drive(P_A, 1'b0); drive(P_R, 1'b0);
    chk("bad.cycles2", 32'(cycles), 32'd2);
    drive(P_G, 1'b0); chk_state("bad.RtoG", 1'b1, 2'd2, 1'b1, 2'd2);
    drive(P_A, 1'b0); chk_state("bad.then_A", 1'b1, 2'd3, 1'b1, 2'd2);

    // clr alone, then illegal pattern handling
    drive(P_A, 1'b1);   chk_state("clr.alone", 1'b1, 2'd3, 1'b0, 2'd0);
    drive(3'b111, 1'b0); chk_state("ill.111", 1'b0, 2'd0, 1'b1, 2'd1);
    drive(3'b000, 1'b0); chk_state("ill.000", 1'b0, 2'd0, 1'b1, 2'd1);
    drive(P_RA, 1'b0);   chk_state("ill.relock", 1'b1, 2'd1, 1'b1, 2'd1);

    // New error with clr replaces the held cause
    drive(P_G, 1'b0);    chk_state("clrerr.G", 1'b1, 2'd2, 1'b1, 2'd1);
    drive(P_R, 1'b1);    chk_state("clrerr.badseq", 1'b1, 2'd0, 1'b1, 2'd2);
    drive(P_R, 1'b1);    chk_state("clrerr.clear", 1'b1, 2'd0, 1'b0, 2'd0);
    drive(3'b101, 1'b1); chk_state("clrerr.illegal", 1'b0, 2'd0, 1'b1, 2'd1);

    // Reset mid-sequence at G discards history
    drive(P_R, 1'b0); drive(P_RA, 1'b0); drive(P_G, 1'b0);
    rst = 1'b1; clr = 1'b1;
    drive(P_G, 1'b1);
    rst = 1'b0;
    chk_state("rst.mid", 1'b0, 2'd0, 1'b0, 2'd0);
    chk("rst.mid.phase", 32'(phase), 32'd0);
    chk("rst.mid.cycles", 32'(cycles), 32'd0);
    drive(3'b000, 1'b0); chk_state("rst.unsync_illegal", 1'b0, 2'd0, 1'b0, 2'd0);
    drive(P_R, 1'b0);    chk_state("rst.relock", 1'b1, 2'd0, 1'b0, 2'd0);
    chk("rst.relock.cycles", 32'(cycles), 32'd0);

    // Saturating cycle counter (2 bits)
    for (int i = 0; i < 5; i++) begin
      drive(P_RA, 1'b0); drive(P_G, 1'b0); drive(P_A, 1'b0); drive(P_R, 1'b0);
      chk($sformatf("sat.cycles%0d", i), 32'(cycles), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk("sat.err", 32'(err), 32'd0);

    // Long hold of G
    drive(P_RA, 1'b0);
    drive(P_G, 1'b0);
`ifdef TRAFFIC_MON_STUCK_EN
    drive(P_G, 1'b0); chk_state("stuck.s2", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(P_G, 1'b0); chk_state("stuck.s3", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(P_G, 1'b0); chk_state("stuck.s4", 1'b1, 2'd2, 1'b1, 2'd3);
    drive(P_G, 1'b0); chk_state("stuck.s5", 1'b1, 2'd2, 1'b1, 2'd3);
    drive(P_G, 1'b1); chk_state("stuck.once", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(P_A, 1'b0); chk_state("stuck.move", 1'b1, 2'd3, 1'b0, 2'd0);
`else
    for (int i = 0; i < 99; i++) drive(P_G, 1'b0);
    chk_state("hold100", 1'b1, 2'd2, 1'b0, 2'd0);
    drive(P_A, 1'b0); chk_state("hold100.move", 1'b1, 2'd3, 1'b0, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Passive checker for the UK traffic-light output interface (red, amber, green). It sits beside the light sequencer in the design and decodes the three lamp lines each clock. It verifies that every lamp pattern and phase transition is legal, counts completed light cycles and raises a sticky error with a cause code. It drives nothing back into the sequencer and is used both in silicon as a safety monitor and in benches as a protocol checker.

## Interface
- `CNT_W`, default 8: width of the completed-cycle counter.
- `MAX_HOLD`, default 16: maximum extra consecutive samples a legal pattern may persist. Must be ≥1. Used only with `TRAFFIC_MON_STUCK_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all inputs sampled on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `red`  in  1  red lamp line.
- `amber`  in  1  amber lamp line.
- `green`  in  1  green lamp line.
- `clr`  in  1  clears `err` and `err_code`; does not clear `cycles`.
- `locked`  out  1  monitor is synchronised to a legal pattern.
- `phase`  out  2  decoded phase of the last sample: 0=R, 1=RA, 2=G, 3=A; valid only when `locked`=1.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  cause of the first error since reset/clr: 0=none, 1=ILLEGAL_PATTERN, 2=BAD_SEQ, 3=STUCK.
- `cycles`  out  CNT_W  completed A→R transitions, saturating at all-ones.

## Operation
- Legal patterns ({red,amber,green}):
  - R = 100
  - RA = 110
  - G = 001
  - A = 010
- All other patterns (000, 011, 101, 111) are illegal.
- Legal transitions: hold (same pattern), R→RA, RA→G, G→A, A→R. Any other change between two legal patterns is BAD_SEQ.
- States:
  - UNSYNC (after reset, `locked`=0): no sequence check. The first legal pattern goes to LOCKED with `phase`=decoded pattern. An illegal pattern in UNSYNC is not an error.
  - LOCKED: each sample is checked against the previous `phase`.
- Illegal pattern while LOCKED: error ILLEGAL_PATTERN, go to UNSYNC.
- BAD_SEQ: error; stay LOCKED; `phase` takes the new pattern, so the monitor relocks on it.
- A->R while LOCKED increments `cycles`, saturating.
- Error capture:
  - If `err`=0, the error sets `err`=1 and `err_code`=cause.
  - If `err`=1, `err_code` is frozen at the first cause.
- Priority within one sample: ILLEGAL_PATTERN > BAD_SEQ > STUCK.
- `clr` in the same cycle as a new error: the error wins (`err`=1, `err_code`=new cause). `clr` alone sets `err`=0 and `err_code`=0.

## Timing
- All outputs are registered and reflect the sample taken at the same posedge (visible after that edge). Latency from lamp change to `phase`/`err` update is one clock.
- The monitor accepts a new pattern every cycle. A sequencer that changes phase every clock is legal.
- Reset values (`rst`=1 at posedge; dominates `clr` and all inputs):
  - `locked`=0, `phase`=0, `err`=0, `err_code`=0, `cycles`=0
  - hold counter = 0
- Reset mid-sequence discards history. The first sample after reset only resynchronises and never flags BAD_SEQ.
- `cycles` at all-ones stays all-ones. No wrap.
- Hold counter:
  - Cleared on every phase change and in UNSYNC.
  - Incremented on each LOCKED hold sample.
  - Saturates at `MAX_HOLD`.

## Configuration
- `TRAFFIC_MON_STUCK_EN` defined:
  - The hold counter is compiled in.
  - STUCK is flagged on the sample where the same legal pattern has been seen for `MAX_HOLD`+1 consecutive LOCKED samples.
  - It is flagged once per hold; the counter saturates until the next phase change.
- Not defined:
  - No hold counter is built.
  - Holds are unlimited and `err_code` 3 is never produced.

## Test plan
- Reset, then drive R,RA,G,A,R,RA one per clock → `locked`=1 after the first edge; `phase` 0,1,2,3,0,1; `cycles`=1; `err`=0.
- After lock at R, drive G → `err`=1, `err_code`=2, `locked`=1, `phase`=2. Then drive A → no new error; `err_code` stays 2.
- While locked, drive 111 → `err_code`=1, `locked`=0. Drive 000 → no change. Drive RA → `locked`=1, `phase`=1.
- With `CNT_W`=2, run 5 full cycles → `cycles` = 1,2,3,3,3.
- Assert `clr` alone → `err`=0 and `err_code`=0 next edge. Assert `clr` with an illegal pattern → `err`=1, `err_code`=1. Assert `rst` mid-sequence at G, then drive R → `locked`=1, `err`=0, `cycles`=0.
- With `TRAFFIC_MON_STUCK_EN` and `MAX_HOLD`=3, hold G for 4 samples → `err_code`=3 on the 4th sample, not earlier. Without the macro, hold G for 100 samples → `err`=0.
